word_stream_fifo: RTL and testbench
===================================

Name: word_stream_fifo

Overview:
Synchronous first-word-fall-through word FIFO that sits directly upstream of the word-to-block assembler.
- Buffers WSIZE-bit words from a bus-side producer using a valid/ready handshake.
- Presents the head word to the assembler with a valid/ready handshake.
- Asserts block_avail once a complete block's worth of words is queued, so the assembler can pull a block without stalling mid-block.
- Single clock domain. Replaces edge-triggered trigger_read/trigger_write style with proper handshakes.

Parameters:
WSIZE, 32, word width in bits
DEPTH, 16, number of word slots; power of two, >= BLOCK_WORDS
BLOCK_WORDS, 4, words per assembler block (BSIZE/WSIZE)
AFULL_LEVEL, DEPTH-2, level at or above which almost_full asserts

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of contents
in_data  input  WSIZE  word from producer
in_valid  input  1  producer has a word on in_data
in_ready  output  1  FIFO accepts a word this cycle
out_data  output  WSIZE  head word (fall-through)
out_valid  output  1  out_data holds a valid head word
out_ready  input  1  consumer takes head word this cycle
level  output  clog2(DEPTH)+1  number of words stored, 0..DEPTH
almost_full  output  1  level >= AFULL_LEVEL
block_avail  output  1  level >= BLOCK_WORDS
overflow  output  1  sticky: in_valid seen while full

Behaviour:
- Reset (asynchronous, active-high): rd_ptr=0, wr_ptr=0, overflow=0. Outputs at reset: level=0, out_valid=0, in_ready=1, almost_full=0, block_avail=0. out_data is don't-care while out_valid=0. Memory contents are not cleared.
- Pointers are clog2(DEPTH)+1 bits and wrap naturally. The low bits index memory. level = wr_ptr - rd_ptr, modulo 2^(clog2(DEPTH)+1).
- Full: level==DEPTH. Empty: level==0.
- push = in_valid & in_ready. in_ready = !full, combinational on registered state only; it must not depend on out_ready, so there is no pass-through path.
- pop = out_valid & out_ready. out_valid = !empty.
- out_data = mem[rd_ptr low bits], read combinationally (FWFT).
- Latency: a word pushed at edge N is visible on out_data with out_valid=1 after edge N. Zero-to-one transit is therefore 1 cycle.
- Push: on the clock edge, mem[wr_ptr]<=in_data and wr_ptr++.
- Pop: on the clock edge, rd_ptr++.
- Simultaneous push and pop (neither full nor empty): both happen and level is unchanged.
- When full: in_ready=0 and a pop proceeds normally. A push in the same cycle is refused even though a slot frees up.
- When empty: out_valid=0, so no pop occurs; a push proceeds normally.
- overflow: set on any edge where in_valid=1 and full=1. It is cleared only by reset or flush.
- flush (synchronous): on the edge, rd_ptr<=wr_ptr<=0 and overflow<=0, and it overrides any push or pop that cycle.
- Reset mid-operation: all state clears immediately; queued words are lost.
- almost_full, block_avail and level are derived combinationally from the pointers. All three update in the cycle after the push or pop edge.

Decomposition:
- Shared package (soc_stream_pkg) holds:
  - WORD_WIDTH=32 and BLOCK_WORDS=4;
  - the ilog2/clog2 function;
  - stream handshake helper constants.
- The storage array becomes one sub-module, word_fifo_ram. It has a synchronous write port and an asynchronous read port, and is parameterised by WSIZE and DEPTH.
- The top level holds the pointers, flags and handshake logic.

Test Plan:
1. Reset, then push 0xA0000001..0xA0000004 on consecutive cycles with out_ready=0:
   - level goes 1,2,3,4;
   - block_avail=1 after the 4th edge;
   - out_data=0xA0000001 from the first edge.
2. From the state of test 1, hold out_ready=1 for 4 cycles:
   - out_data sequence is 0xA0000001..0xA0000004;
   - level reaches 0 and out_valid=0;
   - block_avail drops once level=3.
3. With DEPTH=16, push 16 words:
   - almost_full=1 at level 14;
   - in_ready=0 at level 16.
   Then a 17th in_valid with pop=0:
   - overflow=1, level stays 16, and the 17th word is never emitted.
4. Continuous in_valid=1 and out_ready=1 with level=5 for 40 cycles (wraps pointers twice):
   - level stays 5;
   - output order equals input order;
   - no overflow.
5. Assert flush with level=7 while in_valid=1 and out_ready=1:
   - next cycle level=0, out_valid=0, overflow=0;
   - the pushed word is dropped.
6. Assert reset asynchronously mid-cycle with level=9:
   - level=0, out_valid=0 and in_ready=1 immediately, before the next edge;
   - after release, a push of 0x12345678 appears on out_data after one edge.

Source files
------------

// File: rtl/soc_stream_pkg.sv
// rtl/soc_stream_pkg.sv - shared stream constants, handshake encodings and clog2 helper
package soc_stream_pkg;

  localparam int WORD_WIDTH  = 32;
  localparam int BLOCK_WORDS = 4;

  // {valid, ready} pair as seen on one side of a stream handshake
  typedef enum logic [1:0] {
    HS_IDLE  = 2'b00,
    HS_READY = 2'b01,
    HS_STALL = 2'b10,
    HS_XFER  = 2'b11
  } hs_state_t;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/word_fifo_ram.sv
// rtl/word_fifo_ram.sv - word storage with synchronous write and asynchronous read
module word_fifo_ram #(
  parameter int WSIZE = 32,
  parameter int DEPTH = 16
) (
  input  logic                                   clock,
  input  logic                                   write_enable,
  input  logic [soc_stream_pkg::clog2(DEPTH)-1:0] write_addr,
  input  logic [WSIZE-1:0]                       write_data,
  input  logic [soc_stream_pkg::clog2(DEPTH)-1:0] read_addr,
  output logic [WSIZE-1:0]                       read_data
);

  logic [WSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/word_stream_fifo.sv
// rtl/word_stream_fifo.sv - first-word-fall-through word FIFO feeding the block assembler
module word_stream_fifo #(
  parameter int WSIZE       = soc_stream_pkg::WORD_WIDTH,
  parameter int DEPTH       = 16,
  parameter int BLOCK_WORDS = soc_stream_pkg::BLOCK_WORDS,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [WSIZE-1:0]                     in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [WSIZE-1:0]                     out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [soc_stream_pkg::clog2(DEPTH):0] level,
  output logic                                 almost_full,
  output logic                                 block_avail,
  output logic                                 overflow
);

  import soc_stream_pkg::*;

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // The extra pointer bit distinguishes full from empty when the low bits match
  assign level       = wr_ptr - rd_ptr;
  assign full        = (level == PW'(DEPTH));
  assign empty       = (level == '0);
  assign almost_full = (level >= PW'(AFULL_LEVEL));
  assign block_avail = (level >= PW'(BLOCK_WORDS));

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = ({in_valid, in_ready} == HS_XFER);
  assign pop       = ({out_valid, out_ready} == HS_XFER);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (in_valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

  word_fifo_ram #(
    .WSIZE(WSIZE),
    .DEPTH(DEPTH)
  ) u_ram (
    .clock       (clock),
    .write_enable(push && !flush),
    .write_addr  (wr_ptr[AW-1:0]),
    .write_data  (in_data),
    .read_addr   (rd_ptr[AW-1:0]),
    .read_data   (out_data)
  );

endmodule

// File: tb/tb_word_stream_fifo.sv
// tb/tb_word_stream_fifo.sv - self-checking bench for word_stream_fifo against a queue model
module tb_word_stream_fifo;

  localparam int DEPTH = 16;
  localparam int AFULL = DEPTH - 2;
  localparam int BLKW  = 4;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  level;
  logic        almost_full;
  logic        block_avail;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  logic [31:0] q[$];
  bit          ovf;

  word_stream_fifo #(
    .WSIZE(32),
    .DEPTH(DEPTH),
    .BLOCK_WORDS(BLKW),
    .AFULL_LEVEL(AFULL)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .almost_full(almost_full),
    .block_avail(block_avail),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".level"}, 64'(level), 64'(q.size()));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() < DEPTH));
    chk({tag, ".almost_full"}, 64'(almost_full), 64'(q.size() >= AFULL));
    chk({tag, ".block_avail"}, 64'(block_avail), 64'(q.size() >= BLKW));
    chk({tag, ".overflow"}, 64'(overflow), 64'(ovf));
    if (q.size() > 0) chk({tag, ".out_data"}, 64'(out_data), 64'(q[0]));
  endtask

  // One clock of stimulus; the model decides push/pop from its own occupancy
  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    bit was_full;
    bit do_push;
    bit do_pop;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    was_full  = (q.size() == DEPTH);
    do_push   = iv && !was_full;
    do_pop    = ordy && (q.size() > 0);
    @(posedge clock);
    #1;
    if (fl) begin
      q.delete();
      ovf = 1'b0;
    end else begin
      if (iv && was_full) ovf = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ovf       = 1'b0;
    #12;
    check_all("reset");
    reset = 1'b0;

    // Fill one block with the consumer stalled
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
      check_all("t1_fill");
    end
    chk("t1_block_avail", 64'(block_avail), 64'd1);

    // Drain it and watch block_avail fall at level 3
    for (int i = 1; i <= 4; i++) begin
      chk("t2_head", 64'(out_data), 64'(32'hA000_0000 + 32'(i)));
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      check_all("t2_drain");
    end

    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, $urandom, 1'b0, 1'b0);
      check_all("t3_fill");
    end
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check_all("t3_over");
    chk("t3_overflow", 64'(overflow), 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      check_all("t3_drain");
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check_all("t3_flush");

    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    check_all("t4_prime");
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, $urandom, 1'b1, 1'b0);
      check_all("t4_stream");
    end

    cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, $urandom, 1'b0, 1'b0);
    chk("t5_level7", 64'(level), 64'd7);
    cycle(1'b1, 32'h5555_AAAA, 1'b1, 1'b1);
    check_all("t5_flush");
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check_all("t5_after");

    for (int i = 0; i < 9; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    check_all("t6_level9");
    #3;
    reset = 1'b1;
    #1;
    q.delete();
    ovf = 1'b0;
    check_all("t6_async");
    #1;
    reset = 1'b0;
    cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    check_all("t6_post");
    chk("t6_data", 64'(out_data), 64'h1234_5678);

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 63) == 0));
      check_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
